// File: rtl/vmem_pkg.sv
// Shared types for the vector memory responder: FSM states and default lane/vector shapes.
package vmem_pkg;

  localparam int defaultRegisterSize = 8;
  localparam int defaultVectorSize   = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  typedef logic [defaultRegisterSize-1:0] lane_t;
  typedef lane_t [defaultVectorSize-1:0]  vec_t;

endpackage

// File: rtl/vmem_bank.sv
// Lane-wide storage array: synchronous write, combinational read, contents survive reset.
module vmem_bank #(
  parameter int depth = 256,
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/vec_mem_responder.sv
// Scalar/vector load-store responder moving one lane per cycle through a single bank.
// Optional bounds checking is enabled with the VMEM_BOUNDS_CHECK_EN macro.
module vec_mem_responder
  import vmem_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 16,
  parameter int memDepth     = 256
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_write,
  input  logic                                    req_vec,
  input  logic [addrWidth-1:0]                    req_addr,
  input  logic [vectorSize-1:0][registerSize-1:0] req_wdata,
  output logic                                    resp_valid,
  input  logic                                    resp_ready,
  output logic [vectorSize-1:0][registerSize-1:0] resp_rdata,
  output logic                                    resp_err
);

  localparam int idxWidth  = $clog2(memDepth);
  localparam int laneWidth = (vectorSize > 1) ? $clog2(vectorSize) : 1;

  state_t                                 state, state_next;
  logic [laneWidth-1:0]                   lane;
  logic [laneWidth-1:0]                   lane_last;
  logic                                   lane_done;
  logic                                   lat_write;
  logic                                   lat_vec;
  logic                                   lat_err;
  logic [idxWidth-1:0]                    lat_index;
  logic [vectorSize-1:0][registerSize-1:0] lat_wdata;
  logic                                   req_err;
  logic                                   bank_we;
  logic [idxWidth-1:0]                    bank_addr;
  logic [registerSize-1:0]                bank_rdata;

`ifdef VMEM_BOUNDS_CHECK_EN
  // Extra top bit keeps the end-of-access sum from wrapping inside addrWidth.
  logic [addrWidth:0] last_addr;
  assign last_addr = {1'b0, req_addr} + (req_vec ? (addrWidth+1)'(vectorSize - 1) : '0);
  assign req_err   = last_addr >= (addrWidth+1)'(memDepth);
  assign resp_err  = (state == RESP) && lat_err;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;
  assign req_err          = 1'b0;
  assign resp_err         = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign lane_last  = lat_vec ? laneWidth'(vectorSize - 1) : '0;
  // A rejected request spends its single XFER cycle without touching storage.
  assign lane_done  = lat_err || (lane == lane_last);
  assign bank_we    = (state == XFER) && lat_write && !lat_err;
  assign bank_addr  = lat_index + idxWidth'(lane);

  vmem_bank #(
    .depth (memDepth),
    .width (registerSize)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (lat_wdata[lane]),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= '0;
      lat_write  <= 1'b0;
      lat_vec    <= 1'b0;
      lat_err    <= 1'b0;
      lat_index  <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        lat_write  <= req_write;
        lat_vec    <= req_vec;
        lat_err    <= req_err;
        lat_index  <= req_addr[idxWidth-1:0];
        lat_wdata  <= req_wdata;
        lane       <= '0;
        resp_rdata <= '0;
      end else if (state == XFER) begin
        if (!lat_write && !lat_err) resp_rdata[lane] <= bank_rdata;
        lane <= lane_done ? '0 : lane + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = XFER;
      XFER: if (lane_done) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed table-driven bench for vec_mem_responder plus stall and mid-store reset sequences.
module tb_vec_mem_responder;
  import vmem_pkg::*;

  localparam int registerSize = 8;
  localparam int vectorSize   = 4;
  localparam int addrWidth    = 16;
  localparam int memDepth     = 256;
`ifdef VMEM_BOUNDS_CHECK_EN
  localparam bit boundsOn = 1'b1;
`else
  localparam bit boundsOn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic           req_vec = 1'b0;
  logic [15:0]    req_addr = '0;
  vec_t           req_wdata = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  vec_t           resp_rdata;
  logic           resp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        write;
    logic        vec;
    logic [15:0] addr;
    vec_t        wdata;
    int          lat;
    vec_t        rdata;
    logic        err;
  } vector_t;

  vector_t vectors [13];

  vec_mem_responder #(
    .registerSize (registerSize),
    .vectorSize   (vectorSize),
    .addrWidth    (addrWidth),
    .memDepth     (memDepth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_vec    (req_vec),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, and complete the handshake.
  task automatic apply_stimulus(input logic write, input logic vec, input logic [15:0] addr,
                                input vec_t wdata, output int latency, output vec_t rdata,
                                output logic err);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 20) check_output("req_ready wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = write;
    req_vec   = vec;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_vec   = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    latency = 0;
    while (!resp_valid && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_output("req_ready after handshake", 64'(req_ready), 64'd1);
    check_output("resp_valid after handshake", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int   lat;
    vec_t rd;
    logic er;
    int   waited;

    vectors[0]  = '{1'b1, 1'b1, 16'h0010, 32'h44332211, 4, 32'h0, 1'b0};
    vectors[1]  = '{1'b0, 1'b1, 16'h0010, 32'h0, 4, 32'h44332211, 1'b0};
    vectors[2]  = '{1'b0, 1'b0, 16'h0012, 32'h0, 1, 32'h00000033, 1'b0};
    vectors[3]  = '{1'b1, 1'b1, 16'h0020, 32'h01020304, 4, 32'h0, 1'b0};
    vectors[4]  = '{1'b1, 1'b0, 16'h0020, 32'haabbccdd, 1, 32'h0, 1'b0};
    vectors[5]  = '{1'b0, 1'b1, 16'h0020, 32'h0, 4, 32'h010203dd, 1'b0};
    vectors[6]  = '{1'b1, 1'b1, 16'h0000, 32'h93929190, 4, 32'h0, 1'b0};
    vectors[7]  = '{1'b1, 1'b0, 16'h00fe, 32'h0000005e, 1, 32'h0, 1'b0};
    vectors[8]  = '{1'b1, 1'b0, 16'h00ff, 32'h0000005f, 1, 32'h0, 1'b0};
    vectors[9]  = '{1'b1, 1'b1, 16'h00fe, 32'h0d0c0b0a, boundsOn ? 1 : 4, 32'h0, boundsOn};
    vectors[10] = '{1'b0, 1'b0, 16'h00ff, 32'h0, 1, boundsOn ? 32'h5f : 32'h0b, 1'b0};
    vectors[11] = '{1'b0, 1'b0, 16'h00fe, 32'h0, 1, boundsOn ? 32'h5e : 32'h0a, 1'b0};
    vectors[12] = '{1'b0, 1'b1, 16'h0000, 32'h0, 4, boundsOn ? 32'h93929190 : 32'h93920d0c, 1'b0};

    #2;
    check_output("reset resp_valid", 64'(resp_valid), 64'd0);
    check_output("reset resp_rdata", 64'(resp_rdata), 64'd0);
    check_output("reset resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("req_ready after reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vectors[i].write, vectors[i].vec, vectors[i].addr, vectors[i].wdata, lat, rd, er);
      check_output($sformatf("vec%0d latency", i), 64'(lat), 64'(vectors[i].lat));
      check_output($sformatf("vec%0d rdata", i), 64'(rd), 64'(vectors[i].rdata));
      check_output($sformatf("vec%0d err", i), 64'(er), 64'(vectors[i].err));
    end

    // Response stall: outputs must hold and new requests must be refused.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_vec   = 1'b1;
    req_addr  = 16'h0010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waited = 0;
    while (!resp_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("stall latency", 64'(waited), 64'd4);
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("stall%0d resp_valid", c), 64'(resp_valid), 64'd1);
      check_output($sformatf("stall%0d resp_rdata", c), 64'(resp_rdata), 64'h44332211);
      check_output($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
      req_valid = c[0];
      req_write = 1'b1;
      req_addr  = 16'h0010;
      req_wdata = 32'hdeadbeef;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_output("stall release req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output("no ghost request", 64'(resp_valid), 64'd0);
    apply_stimulus(1'b0, 1'b1, 16'h0010, '0, lat, rd, er);
    check_output("post-stall rdata", 64'(rd), 64'h44332211);

    // Reset after two lanes of a vector store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_vec   = 1'b1;
    req_addr  = 16'h0010;
    req_wdata = 32'ha4a3a2a1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("midreset resp_valid", 64'(resp_valid), 64'd0);
    check_output("midreset req_ready", 64'(req_ready), 64'd1);
    check_output("midreset resp_rdata", 64'(resp_rdata), 64'd0);
    check_output("midreset resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, 16'h0010, '0, lat, rd, er);
    check_output("midreset load latency", 64'(lat), 64'd4);
    check_output("midreset load rdata", 64'(rd), 64'h4433a2a1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vec_mem_responder.md
VEC_MEM_RESPONDER -- requirements
Module: vec_mem_responder

Interface
REQ-001 SHALL have parameter registerSize, default 8, lane width in bits.
REQ-002 SHALL have parameter vectorSize, default 4, lanes per vector.
REQ-003 SHALL have parameter addrWidth, default 16, request address width.
REQ-004 SHALL have parameter memDepth, default 256, lane-sized storage entries (power of two).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  responder can accept a request.
REQ-009 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_vec  input  1  1 = vectorSize lanes, 0 = scalar (lane 0 only).
REQ-011 SHALL have port req_addr  input  addrWidth  base entry address.
REQ-012 SHALL have port req_wdata  input  [vectorSize-1:0][registerSize-1:0]  store data, lane i at base+i.
REQ-013 SHALL have port resp_valid  output  1  response present.
REQ-014 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-015 SHALL have port resp_rdata  output  [vectorSize-1:0][registerSize-1:0]  load data.
REQ-016 SHALL have port resp_err  output  1  access rejected (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, XFER, RESP.
REQ-018 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready; IDLE -> XFER.
REQ-019 SHALL latch req_write, req_vec, req_addr, req_wdata at acceptance; later input changes ignored.
REQ-020 SHALL in XFER process one lane per cycle using lane counter 0..N-1 (N = vectorSize if vector, else 1); last lane -> RESP.
REQ-021 SHALL access entry (base + lane) mod memDepth, using low log2(memDepth) address bits (wrap-around).
REQ-022 SHALL on store write lane data to the addressed entry in that cycle; on load capture combinational read of the entry into resp_rdata[lane].
REQ-023 SHALL drive resp_rdata lanes not read (scalar load unused lanes, every lane on stores) to 0.
REQ-024 SHALL assert resp_valid from edge E+N (E = acceptance edge) and hold resp_valid, resp_rdata, resp_err stable until resp_ready is sampled high; then RESP -> IDLE.
REQ-025 SHALL allow back-to-back: request accepted on the first IDLE cycle after response handshake (one-cycle IDLE bubble minimum).
REQ-026 SHALL make a load following a store to the same entry return the stored value.

Reset
REQ-027 SHALL on rst force IDLE, lane counter 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1 after release.
REQ-028 SHALL NOT clear storage on reset; lanes written before reset mid-store SHALL retain their new values, remaining lanes unchanged.

Configuration
REQ-029 SHALL honour macro VMEM_BOUNDS_CHECK_EN.
REQ-030 With VMEM_BOUNDS_CHECK_EN defined: if req_addr + N - 1 >= memDepth (full addrWidth compare), no storage access, IDLE -> RESP directly, resp_valid from edge E+1, resp_err 1, resp_rdata 0.
REQ-031 Without VMEM_BOUNDS_CHECK_EN: no check, wrap-around per REQ-021, resp_err tied 0.

Structure
REQ-032 SHALL place FSM state enum, lane typedef, vector typedef in shared package vmem_pkg.
REQ-033 SHALL instantiate one sub-module vmem_bank: memDepth x registerSize array, synchronous write, combinational read, no reset.

Verification
REQ-034 Vector store addr 0x10 data {0x44,0x33,0x22,0x11} then vector load 0x10 -> resp_rdata {0x44,0x33,0x22,0x11}, resp_valid 4 cycles after each acceptance.
REQ-035 Scalar load 0x12 after REQ-034 -> resp_rdata {0,0,0,0x33}, resp_valid 1 cycle after acceptance.
REQ-036 Vector store addr 0xFE (memDepth 256, macro off) {D,C,B,A} -> entries 0xFE=A, 0xFF=B, 0x00=C, 0x01=D; resp_err 0.
REQ-037 Same as REQ-036 with VMEM_BOUNDS_CHECK_EN -> resp_err 1 at edge E+1, entries 0xFE,0xFF,0x00,0x01 unchanged.
REQ-038 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout; req_valid pulses ignored.
REQ-039 rst asserted after 2 lanes of vector store -> outputs zero asynchronously, state IDLE; load shows lanes 0-1 new, lanes 2-3 old.
